// File: rtl/cache_2way_param.sv
// cache_2way_param
// ----------------
// Two-way set-associative write-back cache. Each line is 128 bits (eight 16-bit words).
// The CPU side makes 16-bit word accesses. The physical side transfers whole lines.
// A hit completes in the same cycle it is presented. A miss evicts a victim line, writing it
// back first if it is dirty, then fills the new line from memory. The request is then retried
// from IDLE, where it hits.
//
// Parameters:
//   NUM_SETS   - number of sets (power of two, 2..256)
//   ADDR_WIDTH - byte-address width; split as {tag, index, 4-bit offset}
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   mem_address          - CPU byte address (bit 0 ignored)
//   mem_read, mem_write  - CPU request, held until mem_resp (both high = write)
//   mem_byte_enable      - bit1 upper byte, bit0 lower byte of mem_wdata
//   mem_wdata, mem_rdata - CPU write / read word
//   mem_resp             - one-cycle completion strobe (combinational on hit)
//   pmem_address         - line-aligned physical address
//   pmem_read/pmem_write - physical line read / write request
//   pmem_wdata           - victim line being written back
//   pmem_rdata           - fill line
//   pmem_resp            - physical completion
//   hit_count, miss_count, writeback_count
//                        - saturating event counters, present only when
//                          CACHE_PERF_COUNTERS_EN is defined
//
// Build option:
//   CACHE_PERF_COUNTERS_EN - adds the three 32-bit performance counters

module cache_2way_param #(
    parameter int NUM_SETS   = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_byte_enable,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [127:0]          pmem_wdata,
    input  logic [127:0]          pmem_rdata,
`ifdef CACHE_PERF_COUNTERS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           writeback_count,
`endif
    input  logic                  pmem_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state;

    // Per-way storage arrays. Only the valid, dirty and LRU bits are reset.
    logic [127:0]        data_arr [2][NUM_SETS];
    logic [TAG_W-1:0]    tag_arr  [2][NUM_SETS];
    logic [NUM_SETS-1:0] valid    [2];
    logic [NUM_SETS-1:0] dirty    [2];
    logic [NUM_SETS-1:0] lru;

    // The address of the pending miss and the chosen way are captured when the miss is
    // detected. This keeps the writeback and fill independent of the CPU address bus.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             victim_way;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word_sel;
    logic             req;
    logic             hit0;
    logic             hit1;
    logic             hit;
    logic             hit_way;
    logic             vict_way;
    logic [127:0]     hit_line;
    logic [127:0]     merged_line;
    logic             unused_addr_bit;

    assign idx             = mem_address[4 +: IDX_W];
    assign tag             = mem_address[ADDR_WIDTH-1 -: TAG_W];
    assign word_sel        = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];
    assign req             = mem_read | mem_write;

    assign hit0    = valid[0][idx] && (tag_arr[0][idx] == tag);
    assign hit1    = valid[1][idx] && (tag_arr[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Prefer an empty way (way 0 first). Fall back to the least-recently-used way.
    assign vict_way = !valid[0][idx] ? 1'b0 :
                      !valid[1][idx] ? 1'b1 : lru[idx];

    assign hit_line  = data_arr[hit_way][idx];
    assign mem_rdata = hit_line[{word_sel, 4'b0000} +: 16];
    assign mem_resp  = (state == IDLE) && req && hit;

    // Byte-merge the write data into a copy of the hit line.
    always_comb begin
        merged_line = hit_line;
        if (mem_byte_enable[0]) merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    // Controller. The pmem outputs are registered and change only on state transitions.
    // They therefore stay stable while a physical transfer is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            valid[0]     <= '0;
            valid[1]     <= '0;
            dirty[0]     <= '0;
            dirty[1]     <= '0;
            lru          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_resp) begin
                        lru[idx] <= ~hit_way;
                        if (mem_write) begin
                            data_arr[hit_way][idx] <= merged_line;
                            dirty[hit_way][idx]    <= 1'b1;
                        end
                    end else if (req) begin
                        req_idx    <= idx;
                        req_tag    <= tag;
                        victim_way <= vict_way;
                        if (valid[vict_way][idx] && dirty[vict_way][idx]) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_arr[vict_way][idx], idx, 4'b0000};
                            pmem_wdata   <= data_arr[vict_way][idx];
                        end else begin
                            state        <= FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {tag, idx, 4'b0000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[victim_way][req_idx] <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_wdata   <= '0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, 4'b0000};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        data_arr[victim_way][req_idx] <= pmem_rdata;
                        tag_arr[victim_way][req_idx]  <= req_tag;
                        valid[victim_way][req_idx]    <= 1'b1;
                        dirty[victim_way][req_idx]    <= 1'b0;
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    // Saturating event counters. A miss is counted once, when it leaves IDLE.
    // The retried hit that follows is counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else begin
            if (mem_resp && (hit_count != '1))
                hit_count <= hit_count + 32'd1;
            if ((state == IDLE) && req && !hit && (miss_count != '1))
                miss_count <= miss_count + 32'd1;
            if ((state == WRITEBACK) && pmem_resp && (writeback_count != '1))
                writeback_count <= writeback_count + 32'd1;
        end
    end
`endif

endmodule
